plx_lbus_master: RTL
====================

Name: plx_lbus_master

Overview:
- Local-bus initiator. Generates PLX-9030-style single and burst read/write cycles (ADS, ALE, LW_R, LRD, LWR, BLAST, LAD, LA, LBE) toward local-bus targets such as the I/O port bank.
- Completes each beat on the target's READY, and aborts on timeout.
- Serves as the bus-side driver for on-card sequencers and as the bus model for target regression benches.
- A simple command/write-data/read-data handshake sits on the user side.

Parameters:
- ADDR_W, 16, byte-address width driven on LAD during the address phase.
- MAX_LEN_W, 4, width of the burst length field; maximum burst is 2^MAX_LEN_W beats.
- MIN_WAIT, 1, minimum data-phase cycles before READY is sampled; 0 is allowed.
- TIMEOUT_CYC, 64, data-phase cycles without READY before a beat is aborted.

Ports:
- LClk  in  1  local bus clock; all logic on its rising edge.
- LRstN  in  1  asynchronous active-low reset.
- CmdValid  in  1  command request.
- CmdReady  out  1  command accepted when CmdValid & CmdReady.
- CmdWrite  in  1  1 = write, 0 = read.
- CmdAddr  in  ADDR_W  byte address, word-aligned; bits [1:0] ignored.
- CmdBE  in  4  active-high byte enables, used for all beats.
- CmdLen  in  MAX_LEN_W  beats minus one.
- WrValid  in  1  write beat data valid.
- WrReady  out  1  write beat data taken.
- WrData  in  32  write beat data.
- RdValid  out  1  one-cycle pulse with read beat data.
- RdData  out  32  read beat data.
- Done  out  1  one-cycle pulse at end of command.
- TimedOut  out  1  qualifies Done; 1 = command aborted.
- ADS  out  1  active-low address strobe.
- ALE  out  1  active-high address latch enable.
- LW_R  out  1  1 = write cycle, 0 = read cycle.
- LRD  out  1  active-low read strobe.
- LWR  out  1  active-low write strobe.
- BLAST  out  1  active-low last-beat indicator.
- LA  out  7  word address [8:2] of the current beat.
- LBE  out  4  active-low byte enables.
- READY  in  1  active-low target ready.
- LAD_o  out  32  LAD output value.
- LAD_oe  out  1  LAD output enable; the tristate is built at the pad level.
- LAD_i  in  32  LAD input value.

Behaviour:
- Reset values:
  - ADS, LRD, LWR, BLAST, LBE all 1; ALE, LW_R, LAD_oe all 0.
  - CmdReady = 1 (IDLE); WrReady, RdValid, Done, TimedOut = 0.
  - LA = 0, LAD_o = 0, RdData = 0.
  - Reset mid-cycle returns to IDLE immediately with strobes deasserted; no Done is issued.
- States: IDLE, ADDR, LOAD, DATA, RECOV.
- IDLE:
  - CmdReady = 1.
  - On accept, latch the command, set beat counter = CmdLen, go to ADDR.
- ADDR (1 cycle):
  - ADS = 0, ALE = 1, LAD_oe = 1, LAD_o = zero-extended CmdAddr, LW_R = CmdWrite, LA = CmdAddr[8:2], LBE = ~CmdBE.
  - Next state: LOAD if write, DATA if read.
- LOAD (write only):
  - WrReady = 1 until WrValid; capture WrData; go to DATA the next cycle.
  - Strobes stay high while waiting; there is no limit on this wait.
- DATA:
  - Read: LRD = 0 and LAD_oe = 0 from the first DATA cycle.
  - Write: LWR = 0, LAD_oe = 1, LAD_o = captured data.
  - BLAST = 0 when the beat counter is 0.
  - A wait counter starts at 0 on entry. READY is sampled only once the counter is ≥ MIN_WAIT.
- Beat completes on the rising edge where READY = 0 is sampled:
  - On read, RdData = LAD_i and RdValid pulses on the next cycle.
  - Then, if counter ≠ 0: decrement, LA increments and wraps modulo 128, re-enter LOAD (write) or DATA (read). No new ADS.
  - If counter = 0: go to RECOV.
- Timeout: if the wait counter reaches TIMEOUT_CYC with no READY, abort the remaining beats, set TimedOut, go to RECOV. No RdValid for the aborted beat.
- RECOV (1 cycle): all strobes high, LAD_oe = 0 (bus turnaround). Done pulses here; TimedOut is valid with Done. Then go to IDLE.
- Back-to-back commands: the minimum gap is ADDR-to-ADDR = beats + 3 cycles.
- READY low during ADDR or LOAD is ignored.

Optional Feature:
- Macro: LBUS_FIXED_WAIT_EN.
- Defined: READY is ignored. Each beat completes exactly MIN_WAIT+1 cycles after entering DATA. The timeout counter and logic are removed, and TimedOut is tied to 0.
- Undefined: READY handshake and timeout as above.

Test Plan:
- Single write, CmdAddr=0x0004, CmdBE=4'hF, WrData=0x00A5A5A5, target READY low on the 2nd DATA cycle, MIN_WAIT=1 -> ADS low one cycle with LAD=0x0004, LA=7'h01, LW_R=1, LWR low 2 cycles with BLAST low, Done pulse, TimedOut=0.
- Single read, CmdAddr=0x0010, target returns 0x00123456 -> LAD_oe=0 from first DATA cycle, RdValid once with RdData=0x00123456, LRD high in RECOV.
- 4-beat write burst at 0x0000, WrValid withheld 3 cycles before beat 3 -> one ADS only; LA 0,1,2,3; LWR high during the stall; BLAST low only on beat 4; one Done.
- Read with READY never asserted, TIMEOUT_CYC=64 -> LRD low exactly 64 cycles, no RdValid, Done with TimedOut=1, next command accepted normally.
- LRstN asserted mid-burst in DATA -> all strobes high and LAD_oe=0 asynchronously, CmdReady=1 after release, no Done.
- LBUS_FIXED_WAIT_EN defined, MIN_WAIT=2, READY held high -> each beat completes in 3 cycles, TimedOut always 0.

Source files
------------

// File: rtl/plx_lbus_master_if.sv
// rtl/plx_lbus_master_if.sv - user command/data handshake and local-bus signal bundle
// The master modport is the bus initiator's view; slave is the user/target side.
interface plx_lbus_master_if #(
  parameter int ADDR_W    = 16,
  parameter int MAX_LEN_W = 4
);
  logic                 CmdValid;
  logic                 CmdReady;
  logic                 CmdWrite;
  logic [ADDR_W-1:0]    CmdAddr;
  logic [3:0]           CmdBE;
  logic [MAX_LEN_W-1:0] CmdLen;
  logic                 WrValid;
  logic                 WrReady;
  logic [31:0]          WrData;
  logic                 RdValid;
  logic [31:0]          RdData;
  logic                 Done;
  logic                 TimedOut;
  logic                 ADS;
  logic                 ALE;
  logic                 LW_R;
  logic                 LRD;
  logic                 LWR;
  logic                 BLAST;
  logic [6:0]           LA;
  logic [3:0]           LBE;
  logic                 READY;
  logic [31:0]          LAD_o;
  logic                 LAD_oe;
  logic [31:0]          LAD_i;

  modport master (
    input  CmdValid, CmdWrite, CmdAddr, CmdBE, CmdLen, WrValid, WrData, READY, LAD_i,
    output CmdReady, WrReady, RdValid, RdData, Done, TimedOut,
           ADS, ALE, LW_R, LRD, LWR, BLAST, LA, LBE, LAD_o, LAD_oe
  );

  modport slave (
    output CmdValid, CmdWrite, CmdAddr, CmdBE, CmdLen, WrValid, WrData, READY, LAD_i,
    input  CmdReady, WrReady, RdValid, RdData, Done, TimedOut,
           ADS, ALE, LW_R, LRD, LWR, BLAST, LA, LBE, LAD_o, LAD_oe
  );
endinterface

// File: rtl/plx_lbus_master.sv
// rtl/plx_lbus_master.sv - PLX-9030-style local-bus initiator, single and burst read/write
// LBUS_FIXED_WAIT_EN: ignore READY, complete each beat after MIN_WAIT+1 data cycles, no timeout.
module plx_lbus_master #(
  parameter int ADDR_W      = 16,
  parameter int MAX_LEN_W   = 4,
  parameter int MIN_WAIT    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 LClk,
  input  logic                 LRstN,
  plx_lbus_master_if.master    bus
);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + MIN_WAIT + 2);
  localparam logic [WAIT_W-1:0] MIN_WAIT_C = WAIT_W'(MIN_WAIT);
`ifndef LBUS_FIXED_WAIT_EN
  localparam logic [WAIT_W-1:0] TO_LAST_C = WAIT_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LOAD  = 3'd2,
    S_DATA  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [MAX_LEN_W-1:0] cnt_q, cnt_d;
  logic [6:0]           la_q, la_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 beat_done;
  logic                 beat_abort;
`ifndef LBUS_FIXED_WAIT_EN
  logic                 timeout_q, timeout_d;
`endif

  always_ff @(posedge LClk or negedge LRstN) begin
    if (!LRstN) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      la_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_q     <= '0;
      rd_valid_q <= 1'b0;
`ifndef LBUS_FIXED_WAIT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      la_q       <= la_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_q     <= wait_d;
      rd_valid_q <= rd_valid_d;
`ifndef LBUS_FIXED_WAIT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Beat completion: fixed wait count, or READY seen once the minimum wait has elapsed.
  always_comb begin
    beat_done  = 1'b0;
    beat_abort = 1'b0;
`ifdef LBUS_FIXED_WAIT_EN
    beat_done  = (state_q == S_DATA) && (wait_q == MIN_WAIT_C);
`else
    beat_done  = (state_q == S_DATA) && (wait_q >= MIN_WAIT_C) && !bus.READY;
    beat_abort = (state_q == S_DATA) && !beat_done && (wait_q == TO_LAST_C);
`endif
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    la_d       = la_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_d     = wait_q;
    rd_valid_d = 1'b0;
`ifndef LBUS_FIXED_WAIT_EN
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.CmdValid) begin
          write_d   = bus.CmdWrite;
          addr_d    = bus.CmdAddr;
          be_d      = bus.CmdBE;
          cnt_d     = bus.CmdLen;
          la_d      = bus.CmdAddr[8:2];
`ifndef LBUS_FIXED_WAIT_EN
          timeout_d = 1'b0;
`endif
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        wait_d  = '0;
        state_d = write_q ? S_LOAD : S_DATA;
      end
      S_LOAD: begin
        if (bus.WrValid) begin
          wdata_d = bus.WrData;
          wait_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        wait_d = wait_q + 1'b1;
        if (beat_done) begin
          if (!write_q) begin
            rdata_d    = bus.LAD_i;
            rd_valid_d = 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - 1'b1;
            la_d    = la_q + 7'd1;
            wait_d  = '0;
            state_d = write_q ? S_LOAD : S_DATA;
          end else begin
            state_d = S_RECOV;
          end
        end else if (beat_abort) begin
`ifndef LBUS_FIXED_WAIT_EN
          timeout_d = 1'b1;
`endif
          state_d   = S_RECOV;
        end
      end
      S_RECOV: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic in_cmd;
  assign in_cmd = (state_q == S_ADDR) || (state_q == S_LOAD) || (state_q == S_DATA);

  assign bus.CmdReady = (state_q == S_IDLE);
  assign bus.WrReady  = (state_q == S_LOAD);
  assign bus.RdValid  = rd_valid_q;
  assign bus.RdData   = rdata_q;
  assign bus.Done     = (state_q == S_RECOV);
`ifdef LBUS_FIXED_WAIT_EN
  assign bus.TimedOut = 1'b0;
`else
  assign bus.TimedOut = (state_q == S_RECOV) && timeout_q;
`endif

  // Bus strobes decode straight from state so an async reset releases them at once.
  assign bus.ADS    = !(state_q == S_ADDR);
  assign bus.ALE    = (state_q == S_ADDR);
  assign bus.LW_R   = write_q && in_cmd;
  assign bus.LRD    = !((state_q == S_DATA) && !write_q);
  assign bus.LWR    = !((state_q == S_DATA) && write_q);
  assign bus.BLAST  = !((state_q == S_DATA) && (cnt_q == '0));
  assign bus.LA     = la_q;
  assign bus.LBE    = in_cmd ? ~be_q : 4'hF;
  assign bus.LAD_oe = (state_q == S_ADDR) || ((state_q == S_DATA) && write_q);
  assign bus.LAD_o  = (state_q == S_ADDR) ? 32'(addr_q) :
                      ((state_q == S_DATA) && write_q) ? wdata_q : 32'h0;
endmodule
